// File: rtl/ball_speed_ctrl.sv
// Pong ball-speed controller: steps speed up on paddle hits, saturates at SPEED_MAX.
// Define BALL_SPEED_BOOST_EN to add a timed speed boost every BOOST_TICKS rally cycles.
module ball_speed_ctrl #(
    parameter int          SPEED_W       = 10,
    parameter int          SPEED_INIT    = 10,
    parameter int          SPEED_MAX     = 40,
    parameter int          SPEED_STEP    = 1,
    parameter int          HITS_PER_STEP = 1,
    parameter int          HIT_W         = 8,
    parameter int unsigned BOOST_TICKS   = 500_000_000
) (
    input  logic               clk_100MHz,
    input  logic               Reset,
    input  logic               game_start,
    input  logic               calc_start,
    input  logic [2:0]         collision,
    input  logic               point_scored,
    output logic [SPEED_W-1:0] ball_speed,
    output logic               calc_done,
    output logic [HIT_W-1:0]   hit_count,
    output logic               at_max
);

    localparam int SUB_W = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

    if (SPEED_INIT > SPEED_MAX || HITS_PER_STEP < 1 || BOOST_TICKS < 1) begin : g_bad_param
        $error("ball_speed_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, RALLY, UPDATE} state_t;

    state_t             state, state_next;
    logic [2:0]         col_q, col_next;
    logic [SUB_W-1:0]   sub_cnt, sub_next;
    logic [SPEED_W-1:0] speed_next;
    logic [HIT_W-1:0]   hit_next;
    logic               done_next;
    logic               active;
    logic               paddle;
    logic               hit_step;
    logic               step;
    logic [SPEED_W:0]   speed_sum;

    assign active    = game_start && (state != IDLE);
    assign paddle    = game_start && (state == UPDATE) && !point_scored && (col_q[0] | col_q[1]);
    assign hit_step  = paddle && (sub_cnt == SUB_W'(HITS_PER_STEP - 1));
    // One bit of headroom so the increment can never wrap before the ceiling compare.
    assign speed_sum = {1'b0, ball_speed} + (SPEED_W + 1)'(SPEED_STEP);

`ifdef BALL_SPEED_BOOST_EN
    localparam int TMR_W = (BOOST_TICKS > 1) ? $clog2(BOOST_TICKS) : 1;

    logic [TMR_W-1:0] timer;
    logic             boost;

    assign boost = active && !point_scored && (timer == TMR_W'(BOOST_TICKS - 1));
    assign step  = hit_step | boost;

    always_ff @(posedge clk_100MHz or posedge Reset) begin
        if (Reset)
            timer <= '0;
        else if (!active || point_scored || step)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end
`else
    assign step = hit_step;
`endif

    always_comb begin
        state_next = state;
        speed_next = ball_speed;
        hit_next   = hit_count;
        sub_next   = sub_cnt;
        col_next   = col_q;
        done_next  = 1'b0;
        if (!game_start) begin
            state_next = IDLE;
            speed_next = SPEED_W'(SPEED_INIT);
            hit_next   = '0;
            sub_next   = '0;
        end else begin
            unique case (state)
                IDLE:  state_next = RALLY;
                RALLY: begin
                    if (!point_scored && calc_start) begin
                        state_next = UPDATE;
                        col_next   = collision;
                    end
                end
                UPDATE: begin
                    state_next = RALLY;
                    done_next  = 1'b1;
                    if (paddle) begin
                        if (hit_count != '1)
                            hit_next = hit_count + 1'b1;
                        sub_next = hit_step ? '0 : sub_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (step)
                speed_next = (speed_sum > (SPEED_W + 1)'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                                     : speed_sum[SPEED_W-1:0];
            // A scored point overrides any same-cycle update.
            if (point_scored && state != IDLE) begin
                speed_next = SPEED_W'(SPEED_INIT);
                hit_next   = '0;
                sub_next   = '0;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            col_q      <= '0;
            sub_cnt    <= '0;
            ball_speed <= SPEED_W'(SPEED_INIT);
            hit_count  <= '0;
            calc_done  <= 1'b0;
            at_max     <= (SPEED_INIT == SPEED_MAX);
        end else begin
            state      <= state_next;
            col_q      <= col_next;
            sub_cnt    <= sub_next;
            ball_speed <= speed_next;
            hit_count  <= hit_next;
            calc_done  <= done_next;
            at_max     <= (speed_next == SPEED_W'(SPEED_MAX));
        end
    end

endmodule
